mem_issue_arbiter: RTL and testbench
====================================

Name: mem_issue_arbiter

Overview:
- Parametrised successor to the four-slot load/store checker in the issue stage.
- Accepts one decoded bundle of WIDTH instructions and issues it in program order as one or more groups. Each group contains at most MEM_PORTS memory instructions.
- Routes each memory instruction in a group to its memory-capable ALU port.
- Holds blocked instructions internally and replays them on later cycles, so a bundle is never dropped.

Parameters:
- WIDTH, 4, instruction slots per bundle (2..8); slot 0 is oldest.
- MEM_PORTS, 1, memory instructions issuable per group (1..WIDTH).
- OP_W, 4, opcode width.
- LOAD_OP, 4'b0010, load opcode.
- STORE_OP, 4'b0100, store opcode.
- IDX_W, $clog2(WIDTH), slot index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_op  in  WIDTH*OP_W  opcodes; slot i at [i*OP_W +: OP_W].
- in_mask  in  WIDTH  per-slot history-valid bits.
- issue_valid  out  1  group presented.
- issue_ready  in  1  downstream takes the group when issue_valid && issue_ready.
- issue_mask  out  WIDTH  slots in the current group.
- mem_port_valid  out  MEM_PORTS  memory port k has an instruction.
- mem_port_sel  out  MEM_PORTS*IDX_W  slot index routed to port k.
- group_last  out  1  current group empties the bundle.
- replay_count  out  8  saturating count of non-last groups issued.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, op_q=0, pending_q=0, replay_count=0. All outputs 0 except in_ready=1.
- Memory instruction: pending bit set and opcode == LOAD_OP or STORE_OP. Other opcodes are non-memory.
- States:
  - IDLE: no bundle held. issue_valid=0. in_ready=1.
  - HOLD: pending_q != 0. issue_valid=1.
- IDLE transition: on in_valid, latch in_op to op_q and in_mask to pending_q.
  - in_mask != 0 -> HOLD.
  - in_mask == 0 -> bundle consumed silently, stay IDLE.
- Group formation is combinational from op_q and pending_q. Scan slots 0..WIDTH-1 and include pending slots in order. Stop at the first pending memory slot that would be the (MEM_PORTS+1)-th memory instruction; that slot and every later slot are excluded, even non-memory ones (strict in-order).
- Port mapping: the k-th memory slot in the group (k from 0) drives mem_port_valid[k]=1 and mem_port_sel[k]=its index. Unused ports have valid=0 and sel=0.
- group_last = issue_valid && (pending_q & ~issue_mask) == 0.
- Issue fire (issue_valid && issue_ready):
  - pending_q <= pending_q & ~issue_mask.
  - If group_last: go to IDLE. If in_valid is also high, accept the new bundle in the same cycle (in_ready = fire && group_last) and go to HOLD, or stay IDLE if the new mask is 0. No bubble.
  - If not group_last: replay_count increments, saturating at 255.
- issue_ready=0 in HOLD: all outputs held stable, in_ready=0, nothing changes.
- Latency: a bundle accepted at edge N presents its first group in cycle N+1. Worst case is WIDTH groups.
- Reset asserted mid-bundle: the pending bundle is discarded and nothing is replayed.
- An invalid slot never issues and never counts as a memory instruction, whatever its opcode.

Test Plan:
1. WIDTH=4, MEM_PORTS=1; ops {ALU,LD,ST,ALU}, mask 1111 -> group1 mask 0011, port0 sel=1, group_last=0. Group2 mask 1100, port0 sel=2, group_last=1. replay_count=1.
2. Ops {LD,LD,LD,LD}, mask 1111, issue_ready=1 -> four groups 0001, 0010, 0100, 1000 with sel 0,1,2,3. in_ready high only in the last group cycle. replay_count=3.
3. Ops {ST,ALU,LD,ALU}, mask 1010 -> single group mask 1010 with no port valid (slot 2 invalid, slot 0 invalid). Then mask 0000 -> accepted, no issue_valid.
4. MEM_PORTS=2, ops {LD,ST,ALU,LD}, mask 1111 -> group1 0111 (port0=0, port1=1); group2 1000 (port0=3).
5. Hold group1 of scenario 1 with issue_ready=0 for 5 cycles -> outputs stable, in_ready=0. Release -> identical sequence. Back-to-back second bundle accepted on the group_last fire edge with no idle cycle.
6. Assert rst_n=0 asynchronously during group2 -> issue_valid drops immediately, replay_count=0. After release, in_ready=1.

Source files
------------

// File: rtl/mem_issue_arbiter.sv
// mem_issue_arbiter: issues a decoded bundle in program order as groups of at most
// MEM_PORTS memory instructions, routing each memory slot to its memory port.
module mem_issue_arbiter #(
    parameter int              WIDTH     = 4,
    parameter int              MEM_PORTS = 1,
    parameter int              OP_W      = 4,
    parameter logic [OP_W-1:0] LOAD_OP   = 4'b0010,
    parameter logic [OP_W-1:0] STORE_OP  = 4'b0100,
    parameter int              IDX_W     = $clog2(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*OP_W-1:0]      in_op,
    input  logic [WIDTH-1:0]           in_mask,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [WIDTH-1:0]           issue_mask,
    output logic [MEM_PORTS-1:0]       mem_port_valid,
    output logic [MEM_PORTS*IDX_W-1:0] mem_port_sel,
    output logic                       group_last,
    output logic [7:0]                 replay_count
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [WIDTH*OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]        pending_q, pending_d;
    logic [7:0]              replay_q, replay_d;
    logic [IDX_W:0]          mem_cnt;
    logic                    is_mem, stop, fire, accept;

    // Strict in-order: the first memory slot beyond the port budget closes the group.
    always_comb begin
        issue_mask     = '0;
        mem_port_valid = '0;
        mem_port_sel   = '0;
        mem_cnt        = '0;
        stop           = 1'b0;
        is_mem         = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            is_mem = pending_q[i] && (op_q[i*OP_W +: OP_W] == LOAD_OP || op_q[i*OP_W +: OP_W] == STORE_OP);
            if (is_mem && mem_cnt == (IDX_W+1)'(MEM_PORTS))
                stop = 1'b1;
            if (pending_q[i] && !stop) begin
                issue_mask[i] = 1'b1;
                if (is_mem) begin
                    for (int k = 0; k < MEM_PORTS; k++) begin
                        if (mem_cnt == (IDX_W+1)'(k)) begin
                            mem_port_valid[k]               = 1'b1;
                            mem_port_sel[k*IDX_W +: IDX_W]  = IDX_W'(i);
                        end
                    end
                    mem_cnt = mem_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        issue_valid  = state_q == HOLD;
        group_last   = issue_valid && ((pending_q & ~issue_mask) == '0);
        fire         = issue_valid && issue_ready;
        in_ready     = !issue_valid || (fire && group_last);
        accept       = in_valid && in_ready;
        pending_d    = accept ? in_mask : (fire ? (pending_q & ~issue_mask) : pending_q);
        op_d         = accept ? in_op : op_q;
        state_d      = (pending_d != '0) ? HOLD : IDLE;
        replay_d     = (fire && !group_last && replay_q != 8'hFF) ? replay_q + 8'd1 : replay_q;
        replay_count = replay_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            pending_q <= '0;
            replay_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pending_q <= pending_d;
            replay_q  <= replay_d;
        end
    end
endmodule

// File: tb/tb_mem_issue_arbiter.sv
// tb_mem_issue_arbiter: two instances (one and two memory ports) checked every cycle
// against a queue-based model of the grouping rules, plus directed literal checks.
module tb_mem_issue_arbiter;
    localparam logic [3:0] LD = 4'b0010;
    localparam logic [3:0] ST = 4'b0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_op = '0;
    logic [3:0]  in_mask = '0;
    logic        issue_ready = 1'b0;

    logic        rdy0, rdy1, iv0, iv1, gl0, gl1;
    logic [3:0]  im0, im1;
    logic        pv0;
    logic [1:0]  pv1, ps0;
    logic [3:0]  ps1;
    logic [7:0]  rc0, rc1;

    int checks = 0;
    int errors = 0;

    logic [3:0]  mpend [2];
    logic [15:0] mop   [2];
    int          mrc   [2];

    always #5 clk = ~clk;

    mem_issue_arbiter #(.WIDTH(4), .MEM_PORTS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_op(in_op),
        .in_mask(in_mask), .issue_valid(iv0), .issue_ready(issue_ready), .issue_mask(im0),
        .mem_port_valid(pv0), .mem_port_sel(ps0), .group_last(gl0), .replay_count(rc0));

    mem_issue_arbiter #(.WIDTH(4), .MEM_PORTS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op),
        .in_mask(in_mask), .issue_valid(iv1), .issue_ready(issue_ready), .issue_mask(im1),
        .mem_port_valid(pv1), .mem_port_sel(ps1), .group_last(gl1), .replay_count(rc1));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Group = longest prefix of the pending-slot list holding at most mp memory ops.
    function automatic void model_group(input logic [15:0] ops, input logic [3:0] pend, input int mp,
                                        output logic [3:0] m, output logic [1:0] pv, output logic [3:0] ps);
        int slots[$];
        int mems;
        logic [3:0] o;
        m = '0; pv = '0; ps = '0; mems = 0;
        for (int i = 0; i < 4; i++) if (pend[i]) slots.push_back(i);
        for (int j = 0; j < slots.size(); j++) begin
            o = ops[slots[j]*4 +: 4];
            if (o == LD || o == ST) begin
                if (mems == mp) break;
                pv[mems] = 1'b1;
                ps[mems*2 +: 2] = 2'(slots[j]);
                mems++;
            end
            m[slots[j]] = 1'b1;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] m, np;
        logic [1:0] pv;
        logic [3:0] ps;
        logic       v, last, fire;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mpend[d] <= '0;
                mop[d]   <= '0;
                mrc[d]   <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                model_group(mop[d], mpend[d], d + 1, m, pv, ps);
                v    = mpend[d] != 0;
                last = v && ((mpend[d] & ~m) == 0);
                fire = v && issue_ready;
                np   = fire ? (mpend[d] & ~m) : mpend[d];
                if (fire && !last && mrc[d] < 255) mrc[d] <= mrc[d] + 1;
                if (in_valid && (!v || (fire && last))) begin
                    np = in_mask;
                    mop[d] <= in_op;
                end
                mpend[d] <= np;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] m;
        logic [1:0] pv;
        logic [3:0] ps;
        logic       v, last;
        for (int d = 0; d < 2; d++) begin
            model_group(mop[d], mpend[d], d + 1, m, pv, ps);
            v    = mpend[d] != 0;
            last = v && ((mpend[d] & ~m) == 0);
            chk($sformatf("u%0d.issue_valid", d), 16'(d == 0 ? iv0 : iv1), 16'(v));
            chk($sformatf("u%0d.in_ready", d), 16'(d == 0 ? rdy0 : rdy1), 16'(!v || (issue_ready && last)));
            chk($sformatf("u%0d.issue_mask", d), 16'(d == 0 ? im0 : im1), 16'(m));
            chk($sformatf("u%0d.group_last", d), 16'(d == 0 ? gl0 : gl1), 16'(last));
            chk($sformatf("u%0d.port_valid", d), 16'(d == 0 ? {1'b0, pv0} : pv1), 16'(pv));
            chk($sformatf("u%0d.port_sel", d), 16'(d == 0 ? {2'b0, ps0} : ps1), 16'(ps));
            chk($sformatf("u%0d.replay_count", d), 16'(d == 0 ? rc0 : rc1), 16'(mrc[d]));
        end
    end

    function automatic logic [3:0] rand_op();
        int r;
        r = $urandom_range(0, 3);
        return r == 0 ? LD : r == 1 ? ST : r == 2 ? 4'h0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 16'(rdy0), 16'h1);
        chk("reset_issue_valid", 16'(iv0), 16'h0);
        chk("reset_replay", 16'(rc0), 16'h0);
        #1 rst_n = 1'b1;
        // ops {ALU,LD,ST,ALU}, held with issue_ready low
        @(negedge clk);
        #1 in_valid = 1'b1; in_op = 16'h0420; in_mask = 4'hF; issue_ready = 1'b0;
        @(negedge clk);
        chk("s1_g1_mask", 16'(im0), 16'h3);
        chk("s1_g1_sel", 16'(ps0), 16'h1);
        chk("s1_g1_last", 16'(gl0), 16'h0);
        chk("s1_mp2_mask", 16'(im1), 16'hF);
        chk("s1_mp2_sel", 16'(ps1), 16'h9);
        #1 in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_mask", 16'(im0), 16'h3);
            chk("hold_in_ready", 16'(rdy0), 16'h0);
        end
        #1 issue_ready = 1'b1;
        @(negedge clk);
        chk("s1_g2_mask", 16'(im0), 16'hC);
        chk("s1_g2_sel", 16'(ps0), 16'h2);
        chk("s1_g2_last", 16'(gl0), 16'h1);
        chk("s1_replay", 16'(rc0), 16'h1);
        // back-to-back: {LD,LD,LD,LD} taken on the group_last fire edge
        #1 in_valid = 1'b1; in_op = 16'h2222; in_mask = 4'hF;
        @(negedge clk);
        chk("s2_g1_mask", 16'(im0), 16'h1);
        chk("s2_g1_in_ready", 16'(rdy0), 16'h0);
        chk("s2_mp2_sel", 16'(ps1), 16'h4);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("s2_g3_mask", 16'(im0), 16'h4);
        @(negedge clk);
        chk("s2_g4_in_ready", 16'(rdy0), 16'h1);
        chk("s2_replay", 16'(rc0), 16'h4);
        @(negedge clk);
        chk("s2_mp2_replay", 16'(rc1), 16'h1);
        // ops {ST,ALU,LD,ALU}, mask 1010, then an empty bundle
        #1 in_valid = 1'b1; in_op = 16'h0204; in_mask = 4'hA;
        @(negedge clk);
        chk("s3_mask", 16'(im0), 16'hA);
        chk("s3_port_valid", 16'(pv0), 16'h0);
        chk("s3_last", 16'(gl0), 16'h1);
        #1 in_mask = 4'h0;
        @(negedge clk);
        chk("s3_empty_valid", 16'(iv0), 16'h0);
        // ops {LD,ST,ALU,LD} on the two-port instance
        #1 in_op = 16'h2042; in_mask = 4'hF;
        @(negedge clk);
        chk("s4_g1_mask", 16'(im1), 16'h7);
        chk("s4_g1_valid", 16'(pv1), 16'h3);
        chk("s4_g1_sel", 16'(ps1), 16'h4);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("s4_g2_mask", 16'(im1), 16'h8);
        chk("s4_g2_sel", 16'(ps1), 16'h3);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (c == 1500) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            in_valid    = $urandom_range(0, 1) == 1;
            in_op       = {rand_op(), rand_op(), rand_op(), rand_op()};
            in_mask     = 4'($urandom_range(0, 15));
            issue_ready = $urandom_range(0, 3) != 0;
        end
        #1 in_valid = 1'b0; issue_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1 in_valid = 1'b1; in_op = 16'h0420; in_mask = 4'hF;
        @(negedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("s6_g2_mask", 16'(im0), 16'hC);
        #3 rst_n = 1'b0;
        #1;
        chk("s6_async_valid", 16'(iv0), 16'h0);
        chk("s6_async_replay", 16'(rc0), 16'h0);
        chk("s6_async_in_ready", 16'(rdy0), 16'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("s6_after_in_ready", 16'(rdy0), 16'h1);
        chk("s6_after_valid", 16'(iv0), 16'h0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
